// File: rtl/trojan_response_checker.sv
// Compares observed pattern/response pairs against a loadable golden table.
// It counts mismatches, records the first failing pattern and tracks pattern coverage for each run.
module trojan_response_checker #(
    parameter int PW = 4
) (
    input  logic                 CK,
    input  logic                 reset,
    input  logic                 load_valid,
    input  logic [PW-1:0]        load_addr,
    input  logic                 load_data,
    input  logic                 start,
    input  logic                 obs_valid,
    input  logic [PW-1:0]        obs_pattern,
    input  logic                 obs_resp,
    output logic                 obs_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [PW:0]          mismatch_cnt,
    output logic                 first_fail_valid,
    output logic [PW-1:0]        first_fail_pattern,
    output logic [(2**PW)-1:0]   coverage
);

    // state | meaning
    // IDLE  | waiting for start, golden table writable
    // RUN   | accepting and checking observations
    // DONE  | every pattern seen, results held, table writable
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int         DEPTH   = 2**PW;
    localparam logic [PW:0] CNT_MAX = '1;

    logic [1:0]       state_q, state_d;
    logic [DEPTH-1:0] golden_q, golden_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             ffv_q, ffv_d;
    logic [PW-1:0]    ffp_q, ffp_d;
    logic [DEPTH-1:0] cov_q, cov_d;
    logic             pass_q, pass_d;
    logic             accept;
    logic             miss;

    assign accept = (state_q == S_RUN) && obs_valid;
    assign miss   = obs_resp != golden_q[obs_pattern];

    always_comb begin
        state_d  = state_q;
        golden_d = golden_q;
        cnt_d    = cnt_q;
        ffv_d    = ffv_q;
        ffp_d    = ffp_q;
        cov_d    = cov_q;
        pass_d   = pass_q;

        if ((state_q != S_RUN) && load_valid) begin
            golden_d[load_addr] = load_data;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    ffv_d   = 1'b0;
                    ffp_d   = '0;
                    cov_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (accept) begin
                    if (miss) begin
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        if (!ffv_q) begin
                            ffv_d = 1'b1;
                            ffp_d = obs_pattern;
                        end
                    end
                    cov_d[obs_pattern] = 1'b1;
                    // The completing observation's own compare is already folded into cnt_d.
                    if (&cov_d) begin
                        state_d = S_DONE;
                        pass_d  = (cnt_d == '0);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            golden_q <= '0;
            cnt_q    <= '0;
            ffv_q    <= 1'b0;
            ffp_q    <= '0;
            cov_q    <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            golden_q <= golden_d;
            cnt_q    <= cnt_d;
            ffv_q    <= ffv_d;
            ffp_q    <= ffp_d;
            cov_q    <= cov_d;
            pass_q   <= pass_d;
        end
    end

    assign obs_ready          = (state_q == S_RUN);
    assign busy               = (state_q == S_RUN);
    assign done               = (state_q == S_DONE);
    assign pass               = pass_q;
    assign mismatch_cnt       = cnt_q;
    assign first_fail_valid   = ffv_q;
    assign first_fail_pattern = ffp_q;
    assign coverage           = cov_q;

endmodule

// File: tb/tb_trojan_response_checker.sv
// Scoreboard bench for trojan_response_checker with a set-based reference model.
// The model tracks the set of seen patterns and a saturating mismatch count.
module tb_trojan_response_checker;

    logic        CK = 1'b0;
    logic        reset = 1'b0;
    logic        load_valid = 1'b0;
    logic [3:0]  load_addr = '0;
    logic        load_data = 1'b0;
    logic        start = 1'b0;
    logic        obs_valid = 1'b0;
    logic [3:0]  obs_pattern = '0;
    logic        obs_resp = 1'b0;
    logic        obs_ready, busy, done, pass, first_fail_valid;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  first_fail_pattern;
    logic [15:0] coverage;

    trojan_response_checker #(.PW(4)) dut (
        .CK(CK), .reset(reset),
        .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
        .start(start),
        .obs_valid(obs_valid), .obs_pattern(obs_pattern), .obs_resp(obs_resp),
        .obs_ready(obs_ready), .busy(busy), .done(done), .pass(pass),
        .mismatch_cnt(mismatch_cnt), .first_fail_valid(first_fail_valid),
        .first_fail_pattern(first_fail_pattern), .coverage(coverage)
    );

    always #5 CK = ~CK;

    typedef struct {
        int         cnt;
        bit         ffv;
        int         ffp;
        logic [15:0] cov;
        bit         done;
        bit         pass;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // Reference model: 0 = idle, 1 = running, 2 = finished
    bit gold[16];
    bit seen[16];
    int m_state;
    int m_cnt;
    bit m_ffv;
    int m_ffp;
    bit m_pass;

    function automatic logic [15:0] m_cov();
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = seen[i];
        return r;
    endfunction

    function automatic int n_seen();
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(seen[i]);
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            gold[i] = 1'b0;
            seen[i] = 1'b0;
        end
        m_state = 0; m_cnt = 0; m_ffv = 0; m_ffp = 0; m_pass = 0;
    endtask

    task automatic model_step(input bit lv, input int la, input bit ld, input bit st,
                              input bit ov, input int op, input bit orr);
        exp_t e;
        if (m_state != 1) begin
            if (lv) gold[la] = ld;
            if (st) begin
                m_state = 1; m_cnt = 0; m_ffv = 0; m_ffp = 0; m_pass = 0;
                for (int i = 0; i < 16; i++) seen[i] = 1'b0;
            end
        end else if (ov) begin
            if (orr != gold[op]) begin
                if (m_cnt < 31) m_cnt++;
                if (!m_ffv) begin
                    m_ffv = 1;
                    m_ffp = op;
                end
            end
            seen[op] = 1'b1;
            if (n_seen() == 16) begin
                m_state = 2;
                m_pass  = (m_cnt == 0);
            end
            e.cnt = m_cnt; e.ffv = m_ffv; e.ffp = m_ffp; e.cov = m_cov();
            e.done = (m_state == 2); e.pass = m_pass;
            sb.push_back(e);
        end
    endtask

    task automatic tick(input bit lv, input int la, input bit ld, input bit st,
                        input bit ov, input int op, input bit orr);
        @(negedge CK);
        load_valid = lv; load_addr = la[3:0]; load_data = ld; start = st;
        obs_valid = ov; obs_pattern = op[3:0]; obs_resp = orr;
        model_step(lv, la, ld, st, ov, op, orr);
        @(posedge CK);
    endtask

    task automatic idle();
        tick(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic obs(input int p, input bit r);
        tick(0, 0, 0, 0, 1, p, r);
    endtask

    task automatic start_run();
        tick(0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic check_all(input string tag);
        #1;
        chk({tag, ".busy"},      busy,               32'(m_state == 1));
        chk({tag, ".obs_ready"}, obs_ready,          32'(m_state == 1));
        chk({tag, ".done"},      done,               32'(m_state == 2));
        chk({tag, ".pass"},      pass,               32'(m_pass));
        chk({tag, ".cnt"},       mismatch_cnt,       32'(m_cnt));
        chk({tag, ".ffv"},       first_fail_valid,   32'(m_ffv));
        chk({tag, ".ffp"},       first_fail_pattern, 32'(m_ffp));
        chk({tag, ".cov"},       coverage,           32'(m_cov()));
    endtask

    // Monitor: samples the handshake mid-cycle, checks outputs one cycle after the accepting edge.
    initial begin
        bit acc = 0;
        exp_t e;
        forever begin
            @(negedge CK);
            if (acc) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("sb.cnt",  mismatch_cnt,       32'(e.cnt));
                    chk("sb.ffv",  first_fail_valid,   32'(e.ffv));
                    chk("sb.ffp",  first_fail_pattern, 32'(e.ffp));
                    chk("sb.cov",  coverage,           32'(e.cov));
                    chk("sb.done", done,               32'(e.done));
                    chk("sb.pass", pass,               32'(e.pass));
                end
            end
            #1;
            acc = obs_valid && obs_ready && reset;
        end
    end

    initial begin
        int budget;
        model_reset();
        #12;
        check_all("reset");
        reset = 1'b1;

        // All-zero table, all correct responses
        start_run();
        check_all("start1");
        for (int p = 0; p < 16; p++) obs(p, 0);
        check_all("allzero");

        // Single mismatch at pattern 5
        tick(1, 5, 1, 0, 0, 0, 0);
        start_run();
        for (int p = 0; p < 16; p++) obs(p, 0);
        check_all("gold5");

        // Load coinciding with start, then repeated failing pattern 3
        tick(1, 3, 1, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) obs(3, ~gold[3]);
        for (int p = 0; p < 16; p++) if (p != 3) obs(p, gold[p]);
        check_all("rep3");

        // Observations while done are ignored
        for (int k = 0; k < 3; k++) obs($urandom_range(0, 15), $urandom_range(0, 1));
        check_all("done_hold");

        // Random valid gaps with loads attempted during the run
        start_run();
        budget = 0;
        while (m_state == 1 && budget < 3000) begin
            tick($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 1),
                 $urandom_range(0, 15), $urandom_range(0, 1));
            budget++;
        end
        check_all("random");
        chk("random.done", done, 32'd1);

        // Table must be unchanged: responding from the model table gives a clean pass
        start_run();
        for (int p = 15; p >= 0; p--) obs(p, gold[p]);
        check_all("table_kept");
        chk("table_kept.pass", pass, 32'd1);

        // Saturation, with a start issued mid-run
        start_run();
        for (int k = 0; k < 20; k++) obs(0, ~gold[0]);
        start_run();
        for (int k = 0; k < 20; k++) obs(0, ~gold[0]);
        check_all("sat_mid");
        chk("sat.cnt31", mismatch_cnt, 32'd31);
        for (int p = 1; p < 16; p++) obs(p, ~gold[p]);
        check_all("sat_end");

        // Asynchronous reset after 7 accepts
        start_run();
        for (int p = 0; p < 7; p++) obs(p, $urandom_range(0, 1));
        idle();
        @(negedge CK);
        #2;
        reset = 1'b0;
        model_reset();
        check_all("async_rst");
        #4;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) obs(k, 1);
        check_all("post_rst_idle");

        // Golden table was cleared by reset
        start_run();
        for (int p = 0; p < 16; p++) obs(p, 0);
        check_all("gold_cleared");
        chk("gold_cleared.pass", pass, 32'd1);

        idle();
        idle();
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trojan_response_checker.md
TROJAN_RESPONSE_CHECKER -- requirements
Module: trojan_response_checker

Interface
REQ-001 The block SHALL have parameter PW, default 4: pattern width; golden table depth SHALL be 2**PW.
REQ-002 CK  input  1  clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 load_valid  input  1  golden-table write strobe.
REQ-005 load_addr  input  PW  golden-table write address (pattern value).
REQ-006 load_data  input  1  expected response for load_addr.
REQ-007 start  input  1  single-cycle request to begin a check run.
REQ-008 obs_valid  input  1  observed pattern/response pair valid.
REQ-009 obs_pattern  input  PW  applied stimulus pattern.
REQ-010 obs_resp  input  1  observed DUT response for obs_pattern.
REQ-011 obs_ready  output  1  checker accepts an observation this cycle.
REQ-012 busy  output  1  run in progress.
REQ-013 done  output  1  run complete; results stable.
REQ-014 pass  output  1  run completed with zero mismatches.
REQ-015 mismatch_cnt  output  PW+1  count of mismatching observations, saturating.
REQ-016 first_fail_valid  output  1  at least one mismatch recorded this run.
REQ-017 first_fail_pattern  output  PW  pattern of first mismatch in the run.
REQ-018 coverage  output  2**PW  bit k set once pattern k has been observed this run.

Function
REQ-019 FSM SHALL have states IDLE, RUN, DONE; busy=1 only in RUN, done=1 only in DONE, obs_ready=1 only in RUN.
REQ-020 Golden table writes (load_valid=1) SHALL be accepted in IDLE and DONE, written on the clock edge, and ignored in RUN.
REQ-021 IDLE/DONE + start=1 -> RUN next cycle; same edge SHALL clear mismatch_cnt, coverage, first_fail_valid, first_fail_pattern, pass; a simultaneous load_valid in that cycle SHALL still be written.
REQ-022 start in RUN SHALL be ignored.
REQ-023 An observation SHALL be accepted when obs_valid=1 and obs_ready=1; outputs SHALL reflect it one cycle after the accepting edge (latency 1).
REQ-024 Accepted observation SHALL compare obs_resp against golden[obs_pattern]; mismatch increments mismatch_cnt, saturating at 2**(PW+1)-1.
REQ-025 First mismatch of a run SHALL set first_fail_valid=1 and capture obs_pattern; later mismatches SHALL not change first_fail_pattern.
REQ-026 Each accepted observation SHALL set coverage[obs_pattern]; repeated patterns SHALL be compared and counted again, coverage unchanged.
REQ-027 RUN -> DONE on the edge that accepts the observation completing coverage (all ones), that observation's compare included.
REQ-028 On entering DONE, pass SHALL equal (mismatch_cnt==0) including the final observation; pass SHALL be 0 outside DONE.
REQ-029 DONE SHALL hold all results until start or reset; obs_valid in IDLE/DONE SHALL be ignored.

Reset
REQ-030 reset=0 SHALL immediately, regardless of clock, force state IDLE and all outputs to 0 (obs_ready, busy, done, pass, mismatch_cnt, first_fail_valid, first_fail_pattern, coverage).
REQ-031 reset SHALL clear all golden-table entries to 0.
REQ-032 reset asserted mid-run SHALL abandon the run; after release the block SHALL remain in IDLE until start.

Verification
REQ-033 Golden all-0 table, start, feed patterns 0..15 with resp=0 -> done=1 one cycle after 16th accept, pass=1, mismatch_cnt=0, coverage=16'hFFFF.
REQ-034 Load golden[5]=1, feed 0..15 with all resp=0 -> mismatch_cnt=1, first_fail_valid=1, first_fail_pattern=5, pass=0.
REQ-035 Feed pattern 3 three times with wrong resp, then remaining 15 patterns correct -> mismatch_cnt=3, first_fail_pattern=3, done only after 18th accept.
REQ-036 obs_valid toggled randomly, load_valid asserted during RUN -> table unchanged, only valid&ready cycles counted.
REQ-037 Assert reset asynchronously after 7 accepts -> all outputs 0 within same cycle, state IDLE, obs_ready=0 until start.
REQ-038 PW=4, 40 mismatches over repeated patterns -> mismatch_cnt saturates at 31.
